// File: rtl/gesture_av_pkg.sv
`default_nettype none
// ==========================================================================
// gesture_av_pkg : shared types/constants for the gesture A/V front panel
// Revision 1.0
// ==========================================================================
package gesture_av_pkg;

   typedef enum logic [1:0] {
      NOP  = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      MUTE = 2'b11
   } gest_cmd_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      HOLDOFF = 2'd2
   } ctrl_state_t;

   typedef enum logic {
      BUTTON  = 1'b0,
      GESTURE = 1'b1
   } grant_t;

   localparam logic [2:0] VOL_MAX   = 3'd7;
   localparam logic [3:0] DISP_MUTE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ==========================================================================
// button_debouncer : sync + debounce of an active-low button, one pulse/press
// Revision 1.0
// ==========================================================================
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic Clock,
   input  logic nReset,
   input  logic button,
   output logic press
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          reported;
   logic [CW-1:0] count;

   // Synchroniser resets high so an idle button never looks pressed
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sync_1   <= 1'b1;
         sync_2   <= 1'b1;
         count    <= '0;
         reported <= 1'b0;
         press    <= 1'b0;
      end else begin
         sync_1 <= button;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2) begin
            count    <= '0;
            reported <= 1'b0;
         end else if (!reported) begin
            if (count == CNT_LAST) begin
               press    <= 1'b1;
               reported <= 1'b1;
               count    <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/volume_arbiter.sv
`default_nettype none
// ==========================================================================
// volume_arbiter : button/gesture round-robin arbiter owning volume and mute
// Revision 1.0
// ==========================================================================
module volume_arbiter
   import gesture_av_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLDOFF_CYCLES  = 16
) (
   input  logic       Clock,
   input  logic       nReset,
   input  logic       button,
   input  logic       gest_req,
   input  logic [1:0] gest_cmd,
   output logic       gest_ack,
   output logic [2:0] volume_out,
   output logic [3:0] display_value,
   output logic       muted,
   output logic       busy
);

   localparam int            HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

   ctrl_state_t   state, state_n;
   grant_t        grant, grant_n;
   grant_t        last_grant, last_grant_n;
   logic          btn_pending, btn_pending_n;
   logic [HW-1:0] hold_cnt, hold_cnt_n;
   logic [2:0]    volume, volume_n;
   logic          mute_q, mute_n;
   logic          press;
   gest_cmd_t     cmd;

   assign cmd = gest_cmd_t'(gest_cmd);

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .Clock  (Clock),
      .nReset (nReset),
      .button (button),
      .press  (press)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state       <= IDLE;
         grant       <= BUTTON;
         last_grant  <= GESTURE;
         btn_pending <= 1'b0;
         hold_cnt    <= '0;
         volume      <= 3'd0;
         mute_q      <= 1'b0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         last_grant  <= last_grant_n;
         btn_pending <= btn_pending_n;
         hold_cnt    <= hold_cnt_n;
         volume      <= volume_n;
         mute_q      <= mute_n;
      end
   end

   always_comb begin
      state_n       = state;
      grant_n       = grant;
      last_grant_n  = last_grant;
      hold_cnt_n    = hold_cnt;
      volume_n      = volume;
      mute_n        = mute_q;
      btn_pending_n = btn_pending | press;
      gest_ack      = 1'b0;

      case (state)
         IDLE: begin
            if (btn_pending || gest_req) begin
               if (btn_pending && gest_req)
                  grant_n = (last_grant == GESTURE) ? BUTTON : GESTURE;
               else if (btn_pending)
                  grant_n = BUTTON;
               else
                  grant_n = GESTURE;
               last_grant_n = grant_n;
               state_n      = APPLY;
            end
         end

         APPLY: begin
            state_n    = HOLDOFF;
            hold_cnt_n = HOLD_LOAD;
            if (grant == BUTTON) begin
               // A press arriving now is dropped: pending is still set
               btn_pending_n = 1'b0;
               if (mute_q)
                  mute_n = 1'b0;
               else
                  volume_n = volume + 3'd1;
            end else begin
               gest_ack = 1'b1;
               case (cmd)
                  UP: begin
                     mute_n = 1'b0;
                     if (volume != VOL_MAX)
                        volume_n = volume + 3'd1;
                  end
                  DOWN: begin
                     if (volume != 3'd0)
                        volume_n = volume - 3'd1;
                  end
                  MUTE:    mute_n = ~mute_q;
                  default: ;
               endcase
            end
         end

         HOLDOFF: begin
            if (hold_cnt == '0)
               state_n = IDLE;
            else
               hold_cnt_n = hold_cnt - 1'b1;
         end

         default: state_n = IDLE;
      endcase
   end

   assign muted         = mute_q;
   assign volume_out    = mute_q ? 3'd0 : volume;
   assign display_value = mute_q ? DISP_MUTE : {1'b0, volume};
   assign busy          = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_volume_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_volume_arbiter : table, directed and random checks of volume_arbiter
// Revision 1.0
// ==========================================================================
module tb_volume_arbiter;

   localparam int DEB  = 4;
   localparam int HOLD = 16;

   localparam int C_NOP  = 0;
   localparam int C_UP   = 1;
   localparam int C_DOWN = 2;
   localparam int C_MUTE = 3;

   logic       Clock    = 1'b0;
   logic       nReset   = 1'b0;
   logic       button   = 1'b1;
   logic       gest_req = 1'b0;
   logic [1:0] gest_cmd = 2'b00;
   wire        gest_ack;
   wire  [2:0] volume_out;
   wire  [3:0] display_value;
   wire        muted;
   wire        busy;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int ack_total = 0;
   int m_vol;
   int m_mute;

   typedef struct {
      bit is_gest;
      int cmd;
      int len;
      int exp_vo;
      int exp_dv;
      int exp_mu;
   } vec_t;

   vec_t vecs[12];

   volume_arbiter #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .Clock         (Clock),
      .nReset        (nReset),
      .button        (button),
      .gest_req      (gest_req),
      .gest_cmd      (gest_cmd),
      .gest_ack      (gest_ack),
      .volume_out    (volume_out),
      .display_value (display_value),
      .muted         (muted),
      .busy          (busy)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc++;
   always @(negedge Clock) if (gest_ack === 1'b1) ack_total++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Abstract effects of one applied request on the panel state
   function automatic void model_button();
      if (m_mute != 0) m_mute = 0;
      else             m_vol  = (m_vol + 1) % 8;
   endfunction

   function automatic void model_gesture(input int c);
      case (c)
         C_UP:    begin m_mute = 0; m_vol = (m_vol < 7) ? m_vol + 1 : 7; end
         C_DOWN:  m_vol = (m_vol > 0) ? m_vol - 1 : 0;
         C_MUTE:  m_mute = (m_mute != 0) ? 0 : 1;
         default: ;
      endcase
   endfunction

   task automatic wait_ack(output bit got, output int at);
      got = 1'b0;
      at  = -1;
      for (int t = 0; t < 200; t++) begin
         @(negedge Clock);
         if (gest_ack === 1'b1) begin
            got = 1'b1;
            at  = cyc;
            break;
         end
      end
   endtask

   task automatic gesture(input int c, output int at);
      bit got;
      @(posedge Clock); #1;
      gest_req = 1'b1;
      gest_cmd = 2'(c);
      wait_ack(got, at);
      check("gest_ack_seen", 32'(got), 32'd1);
      @(posedge Clock); #1;
      gest_req = 1'b0;
   endtask

   task automatic settle();
      repeat (HOLD + 6) @(posedge Clock);
      #1;
   endtask

   task automatic press(input int len);
      @(posedge Clock); #1;
      button = 1'b0;
      repeat (len) @(posedge Clock);
      #1;
      button = 1'b1;
      repeat (HOLD + 30) @(posedge Clock);
      #1;
   endtask

   task automatic check_state(input string tag, input int vo, input int dv, input int mu);
      @(negedge Clock);
      check({tag, "_volume_out"},    32'(volume_out),    32'(vo));
      check({tag, "_display_value"}, 32'(display_value), 32'(dv));
      check({tag, "_muted"},         32'(muted),         32'(mu));
      check({tag, "_busy"},          32'(busy),          32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_volume_out"},    32'(volume_out),    32'd0);
      check({tag, "_display_value"}, 32'(display_value), 32'd0);
      check({tag, "_muted"},         32'(muted),         32'd0);
      check({tag, "_busy"},          32'(busy),          32'd0);
      check({tag, "_gest_ack"},      32'(gest_ack),      32'd0);
   endtask

   initial begin
      int  at;
      int  a0;
      int  apply_cyc;
      int  ack_at[9];
      bit  got;

      vecs[0]  = '{1'b0, C_NOP,  3,  0, 0,  0};
      vecs[1]  = '{1'b0, C_NOP,  10, 1, 1,  0};
      vecs[2]  = '{1'b1, C_UP,   0,  2, 2,  0};
      vecs[3]  = '{1'b1, C_DOWN, 0,  1, 1,  0};
      vecs[4]  = '{1'b1, C_DOWN, 0,  0, 0,  0};
      vecs[5]  = '{1'b1, C_DOWN, 0,  0, 0,  0};
      vecs[6]  = '{1'b1, C_MUTE, 0,  0, 15, 1};
      vecs[7]  = '{1'b1, C_UP,   0,  1, 1,  0};
      vecs[8]  = '{1'b1, C_NOP,  0,  1, 1,  0};
      vecs[9]  = '{1'b1, C_MUTE, 0,  0, 15, 1};
      vecs[10] = '{1'b1, C_DOWN, 0,  0, 15, 1};
      vecs[11] = '{1'b0, C_NOP,  5,  0, 0,  0};

      // Reset state
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check_reset_outputs("in_reset");
      @(posedge Clock); #1;
      nReset = 1'b1;
      @(negedge Clock);
      check_reset_outputs("after_reset");

      // Table-driven single operations
      for (int i = 0; i < 12; i++) begin
         a0 = ack_total;
         if (!vecs[i].is_gest) begin
            press(vecs[i].len);
         end else begin
            gesture(vecs[i].cmd, at);
            settle();
         end
         check_state($sformatf("vec%0d", i), vecs[i].exp_vo, vecs[i].exp_dv, vecs[i].exp_mu);
         check($sformatf("vec%0d_ack_count", i), 32'(ack_total - a0),
               vecs[i].is_gest ? 32'd1 : 32'd0);
      end

      // UP nine times from 0: saturate at 7, acks spaced HOLD+2 apart
      a0 = ack_total;
      for (int k = 0; k < 9; k++) gesture(C_UP, ack_at[k]);
      settle();
      for (int k = 1; k < 9; k++)
         check($sformatf("up_spacing%0d", k), 32'(ack_at[k] - ack_at[k-1]), 32'(HOLD + 2));
      check("up_ack_pulses", 32'(ack_total - a0), 32'd9);
      check_state("up_saturate", 7, 7, 0);

      // Button wraps 7 -> 0
      press(6);
      check_state("btn_wrap", 0, 0, 0);

      // Button while muted only unmutes
      gesture(C_UP, at);
      settle();
      gesture(C_MUTE, at);
      settle();
      check_state("mute_on", 0, 15, 1);
      press(8);
      check_state("btn_unmute", 1, 1, 0);

      // Tie right after reset: button wins, DOWN served HOLD+2 later
      @(posedge Clock); #1;
      nReset = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      nReset = 1'b1;
      button = 1'b0;
      repeat (7) @(posedge Clock);
      #1;
      gest_req = 1'b1;
      gest_cmd = 2'(C_DOWN);
      a0 = ack_total;
      apply_cyc = -1000;
      for (int t = 0; t < 50; t++) begin
         @(negedge Clock);
         if (busy === 1'b1) begin
            apply_cyc = cyc;
            break;
         end
      end
      check("tie_first_ack_low", 32'(gest_ack), 32'd0);
      wait_ack(got, at);
      check("tie_ack_seen", 32'(got), 32'd1);
      check("tie_ack_delay", 32'(at - apply_cyc), 32'(HOLD + 2));
      @(posedge Clock); #1;
      gest_req = 1'b0;
      button   = 1'b1;
      settle();
      check_state("tie_result", 0, 0, 0);
      check("tie_ack_count", 32'(ack_total - a0), 32'd1);

      // Reset during HOLDOFF with a held request
      gesture(C_UP, at);
      gest_req = 1'b1;
      gest_cmd = 2'(C_MUTE);
      repeat (4) @(posedge Clock);
      #1;
      nReset = 1'b0;
      @(negedge Clock);
      check_reset_outputs("holdoff_reset");
      a0 = ack_total;
      repeat (3) @(posedge Clock);
      #1;
      nReset = 1'b1;
      @(negedge Clock);
      check("post_reset_idle_busy", 32'(busy), 32'd0);
      check("post_reset_idle_ack", 32'(gest_ack), 32'd0);
      check("reset_window_acks", 32'(ack_total - a0), 32'd0);
      wait_ack(got, at);
      check("rearb_ack_seen", 32'(got), 32'd1);
      @(posedge Clock); #1;
      gest_req = 1'b0;
      settle();
      check_state("rearb_mute", 0, 15, 1);

      // Random operations against the reference model
      m_vol  = 0;
      m_mute = 1;
      for (int n = 0; n < 40; n++) begin
         int r;
         int len;
         int c;
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            len = int'($urandom_range(1, 12));
            press(len);
            if (len >= DEB) model_button();
         end else begin
            c = int'($urandom_range(0, 3));
            gesture(c, at);
            settle();
            model_gesture(c);
         end
         check_state($sformatf("rand%0d", n),
                     (m_mute != 0) ? 0 : m_vol,
                     (m_mute != 0) ? 15 : m_vol,
                     m_mute);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/volume_arbiter.md
Name: volume_arbiter

Overview:
- Owns the volume/mute state of the gesture A/V front panel.
- Arbitrates two requesters for that state: the debounced physical button and the gesture-sensor command interface.
- Applies at most one change per HOLDOFF window.
- Drives the LED volume display and the seven-segment display value.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-low cycles required to register a button press.
- HOLDOFF_CYCLES, 16: idle cycles enforced after each applied change. Legal range is 1 or more.

Ports:
- Clock  input  1  system clock.
- nReset  input  1  asynchronous active-low reset.
- button  input  1  raw push button, active low, asynchronous to Clock.
- gest_req  input  1  gesture command request; held high until acknowledged.
- gest_cmd  input  2  gesture command: 00 NOP, 01 UP, 10 DOWN, 11 MUTE. Stable while gest_req is high.
- gest_ack  output  1  one-cycle acknowledge of the gesture command.
- volume_out  output  3  effective volume to the LED display: 0 when muted, otherwise volume.
- display_value  output  4  seven-segment code: 4'hF when muted, otherwise {1'b0, volume}.
- muted  output  1  mute flag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: volume 0, muted 0, gest_ack 0, busy 0, volume_out 0, display_value 0.
- Also on reset: state IDLE, btn_pending 0, last_grant GESTURE (so the button wins the first tie), debouncer cleared.
- Reset asserted mid-operation discards any pending or in-flight request. A gesture requester must re-present its command after reset.
- Button path:
  - Two-flop synchroniser feeds a debounce counter that counts while the synchronised input is low and clears when it is high.
  - When the count reaches DEBOUNCE_CYCLES and the press is not yet reported, emit one press pulse and set btn_pending.
  - The debouncer rearms only after one synchronised-high cycle. One physical press produces exactly one event.
  - A press pulse while btn_pending is already 1 is dropped, not queued.
- States: IDLE, APPLY, HOLDOFF.
- IDLE:
  - Requests seen are btn_pending and gest_req.
  - If exactly one request is present, grant it.
  - If both are present, grant the requester other than last_grant (round-robin).
  - On a grant, register the grant, update last_grant, and go to APPLY on the next edge.
  - With no request, stay in IDLE.
- APPLY (exactly 1 cycle):
  - gest_ack = 1 during this cycle only if the grant is GESTURE.
  - Volume and mute update on the edge that ends APPLY.
  - A button grant clears btn_pending on that same edge.
  - Then go to HOLDOFF with the counter loaded to HOLDOFF_CYCLES-1.
- HOLDOFF:
  - The counter decrements each cycle; go to IDLE on the edge where it equals 0.
  - No grants are made in HOLDOFF. A gest_req stays pending, unacked. A button press still sets btn_pending.
- Button effect:
  - If muted, clear muted; volume unchanged.
  - Otherwise volume = volume + 1, wrapping 7 to 0 (3-bit modular).
- Gesture effects:
  - UP: clear muted; volume saturates at 7.
  - DOWN: volume saturates at 0; muted unchanged.
  - MUTE: toggle muted; volume unchanged.
  - NOP: acknowledged, no state change.
- Latency: a request first seen in IDLE at edge k gives APPLY in cycle k+1. The new outputs are visible from edge k+2.
- Minimum spacing between two applied changes is HOLDOFF_CYCLES+2 cycles.
- volume_out, display_value, and muted are combinational from the registered volume and muted. They carry no extra latency.
- After gest_ack, the requester may present a new command in the very next cycle. It will be served after HOLDOFF.
- Deasserting gest_req before ack withdraws the request. Legal only in IDLE or HOLDOFF, never in APPLY.

Decomposition:
- Package gesture_av_pkg holds:
  - gest_cmd_t enum (NOP, UP, DOWN, MUTE)
  - ctrl_state_t (IDLE, APPLY, HOLDOFF)
  - grant_t (BUTTON, GESTURE)
  - constants VOL_MAX = 3'd7 and DISP_MUTE = 4'hF
- One sub-module, button_debouncer: synchroniser, counter, rearm logic, single-cycle press output.
- The arbiter FSM and volume datapath stay in volume_arbiter.

Test Plan:
- Reset release, then button held low for 10 cycles and released, once: exactly one increment; volume_out = 1, display_value = 1.
- Button low for 3 cycles only (DEBOUNCE_CYCLES = 4): no change, volume stays 0.
- Gesture UP repeated 9 times, req held until each ack: volume saturates at 7. gest_ack pulses 9 times, spaced 18 cycles apart.
- At volume 7, one button press: volume wraps to 0.
- Gesture MUTE: muted = 1, volume_out = 0, display_value = F.
- Then a button press: muted = 0, volume unchanged.
- Button event and gest_req DOWN pending in the same IDLE cycle after reset: button served first. DOWN is acked HOLDOFF_CYCLES+2 cycles later.
- nReset pulsed during HOLDOFF with gest_req high: all outputs return to reset values. gest_ack is not asserted until the held request is re-arbitrated from IDLE.
